id_range_parser: RTL

// - ASCII-to-binary front end of the ingredient range-check chain. Sits between tap_decoder (byte stream) and the

---
 rtl/id_range_parser.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/id_range_parser.sv
// id_range_parser: ASCII-to-binary front end of the ingredient range-check chain.
// Parses "L-U\n" range lines, one blank separator line, then "N\n" ID lines, and
// emits one registered (sel, valid, data) beat per terminated number.
//
// Ports:
//   clk               clock (tck domain)
//   test_logic_reset  async, active-high reset
//   byte_valid        1-cycle strobe qualifying byte_data
//   byte_data         ASCII input byte
//   id_range_sel      1 = range bound beat, 0 = ingredient ID beat
//   id_range_valid    1-cycle strobe qualifying id_range_sel / id_range_data
//   id_range_data     decoded number, INGREDIENT_ID_RANGE_WIDTH bits
//   id_section        set once the blank separator line has been parsed
//   parse_error       sticky flag: unexpected byte or empty field seen
module id_range_parser #(
  parameter int unsigned INGREDIENT_ID_RANGE_WIDTH = 49
) (
  input  logic                                 clk,
  input  logic                                 test_logic_reset,
  input  logic                                 byte_valid,
  input  logic [7:0]                           byte_data,
  output logic                                 id_range_sel,
  output logic                                 id_range_valid,
  output logic [INGREDIENT_ID_RANGE_WIDTH-1:0] id_range_data,
  output logic                                 id_section,
  output logic                                 parse_error
);

  localparam int unsigned W = INGREDIENT_ID_RANGE_WIDTH;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_CR   = 8'h0D;

  typedef enum logic [1:0] {
    RANGE_LO = 2'd0,
    RANGE_HI = 2'd1,
    ID       = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic           digit_seen_q, digit_seen_d;
  logic           valid_q, valid_d;
  logic           sel_q, sel_d;
  logic [W-1:0]   data_q, data_d;
  logic           id_section_q, id_section_d;
  logic           parse_error_q, parse_error_d;

  // Byte classification
  logic           is_digit_c;
  logic           is_dash_c;
  logic           is_lf_c;
  logic           is_cr_c;
  logic [W-1:0]   acc_times10_c;
  logic [W-1:0]   acc_digit_c;

  always_comb begin
    is_digit_c    = (byte_data >= CH_0) && (byte_data <= CH_9);
    is_dash_c     = (byte_data == CH_DASH);
    is_lf_c       = (byte_data == CH_LF);
    is_cr_c       = (byte_data == CH_CR);
    // acc*10 as (acc<<3)+(acc<<1); all terms truncated to W bits so overflow wraps
    acc_times10_c = W'(acc_q << 3) + W'(acc_q << 1);
    // '0'..'9' are 0x30..0x39, so the low nibble is the digit value
    acc_digit_c   = acc_times10_c + W'(byte_data[3:0]);
  end

  // State register
  always_ff @(posedge clk or posedge test_logic_reset) begin
    if (test_logic_reset) begin
      state_q <= RANGE_LO;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; digits, '\r' and rejected bytes never move the FSM
  always_comb begin
    state_d = state_q;
    if (byte_valid && !is_digit_c && !is_cr_c) begin
      unique case (state_q)
        RANGE_LO: begin
          if (is_dash_c && digit_seen_q) begin
            state_d = RANGE_HI;
          end else if (is_lf_c && !digit_seen_q) begin
            state_d = ID;
          end
        end
        RANGE_HI: begin
          if (is_lf_c) begin
            state_d = RANGE_LO;
          end
        end
        ID: begin
          state_d = ID;
        end
        default: begin
          state_d = RANGE_LO;
        end
      endcase
    end
  end

  // Datapath and output next-values
  always_comb begin
    acc_d         = acc_q;
    digit_seen_d  = digit_seen_q;
    valid_d       = 1'b0;
    sel_d         = sel_q;
    data_d        = data_q;
    id_section_d  = id_section_q;
    parse_error_d = parse_error_q;

    if (byte_valid) begin
      if (is_digit_c) begin
        acc_d        = acc_digit_c;
        digit_seen_d = 1'b1;
      end else if (is_cr_c) begin
        acc_d = acc_q;
      end else begin
        unique case (state_q)
          RANGE_LO: begin
            if (is_dash_c && digit_seen_q) begin
              valid_d      = 1'b1;
              sel_d        = 1'b1;
              data_d       = acc_q;
              acc_d        = '0;
              digit_seen_d = 1'b0;
            end else if (is_lf_c && !digit_seen_q) begin
              id_section_d = 1'b1;
            end else if (is_lf_c) begin
              // Lone number with no '-': discard it
              parse_error_d = 1'b1;
              acc_d         = '0;
              digit_seen_d  = 1'b0;
            end else begin
              parse_error_d = 1'b1;
            end
          end
          RANGE_HI: begin
            if (is_lf_c && digit_seen_q) begin
              valid_d      = 1'b1;
              sel_d        = 1'b1;
              data_d       = acc_q;
              acc_d        = '0;
              digit_seen_d = 1'b0;
            end else if (is_lf_c) begin
              parse_error_d = 1'b1;
              acc_d         = '0;
              digit_seen_d  = 1'b0;
            end else begin
              parse_error_d = 1'b1;
            end
          end
          ID: begin
            if (is_lf_c && digit_seen_q) begin
              valid_d      = 1'b1;
              sel_d        = 1'b0;
              data_d       = acc_q;
              acc_d        = '0;
              digit_seen_d = 1'b0;
            end else if (!is_lf_c) begin
              parse_error_d = 1'b1;
            end
          end
          default: begin
            parse_error_d = 1'b1;
          end
        endcase
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge test_logic_reset) begin
    if (test_logic_reset) begin
      acc_q         <= '0;
      digit_seen_q  <= 1'b0;
      valid_q       <= 1'b0;
      sel_q         <= 1'b0;
      data_q        <= '0;
      id_section_q  <= 1'b0;
      parse_error_q <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      digit_seen_q  <= digit_seen_d;
      valid_q       <= valid_d;
      sel_q         <= sel_d;
      data_q        <= data_d;
      id_section_q  <= id_section_d;
      parse_error_q <= parse_error_d;
    end
  end

  assign id_range_valid = valid_q;
  assign id_range_sel   = sel_q;
  assign id_range_data  = data_q;
  assign id_section     = id_section_q;
  assign parse_error    = parse_error_q;

endmodule
